wb_stage: RTL
=============

Name: wb_stage

Overview:
- Parametrised, registered write-back stage. Replaces the purely combinational two-way write-back mux.
- Captures MEM-stage results into a pipeline register.
- Selects among four write-back sources, extracts and sign/zero-extends load data from the raw memory word, and suppresses writes to x0 and misaligned loads.
- Drives the register-file write port one cycle after capture and keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- CNT_W, 32, retire counter width.
- OFF_W, log2(DATA_W/8), derived; byte-offset width. Not to be overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-low.
- valid_i  in  1  MEM-stage result valid.
- ready_o  out  1  stage accepts input this cycle; equals ~stall_i.
- stall_i  in  1  hazard-unit hold request.
- flush_i  in  1  kill the held instruction.
- reg_write_i  in  1  instruction writes rd.
- rd_addr_i  in  REG_AW  destination register.
- wb_sel_i  in  2  source select: 0=ALU, 1=MEM, 2=PC+4, 3=CSR.
- alu_data_i  in  DATA_W  ALU result.
- mem_data_i  in  DATA_W  raw aligned memory word.
- pc_plus4_i  in  DATA_W  link value.
- csr_data_i  in  DATA_W  CSR read value.
- mem_size_i  in  2  load size: 0=byte, 1=half, 2=word, 3=double.
- mem_unsigned_i  in  1  1 = zero-extend, 0 = sign-extend.
- mem_offset_i  in  OFF_W  low address bits of the load.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  REG_AW  register-file write address.
- rf_wdata_o  out  DATA_W  register-file write data.
- valid_o  out  1  pipeline register holds a live instruction.
- misalign_o  out  1  held load is misaligned (registered).
- retire_cnt_o  out  CNT_W  instructions committed.

Behaviour:
- Reset: when rst_i==0 at a rising edge, all state clears.
  - valid_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, misalign_o=0, retire_cnt_o=0.
  - Reset overrides flush, stall and capture.
  - Reset asserted mid-stall drops the held instruction without counting it.
- Register update priority per edge: reset > flush > stall > capture.
  - flush_i=1: valid_q<=0. Other fields are don't-care.
  - Else stall_i=1: all fields hold.
  - Else: capture. valid_q<=valid_i, and all data/control fields load.
- Latency: exactly one cycle from capture to rf_* outputs.
- Write data, computed before the register:
  - wb_sel 0 → alu_data_i.
  - wb_sel 2 → pc_plus4_i.
  - wb_sel 3 → csr_data_i.
  - wb_sel 1 → load extract.
- Load extract:
  - shifted = mem_data_i >> (8*mem_offset_i).
  - Take the low 8/16/32/64 bits per size, then sign- or zero-extend to DATA_W.
  - DATA_W=32, size=3: treated as word.
  - DATA_W=32, word with unsigned=1: equals plain word.
- Misalignment:
  - Applies only when wb_sel==1.
  - Condition: half with offset[0]≠0; word with offset[1:0]≠0; double with offset[2:0]≠0.
  - Result is registered to misalign_o.
- Write enable: rf_we_o = valid_q & reg_write_q & (rd_q≠0) & ~misalign_q & ~stall_i.
  - While stalled, the write is held off.
  - The write commits exactly once, on the first non-stall cycle.
- Write data and address: rf_waddr_o=rd_q, rf_wdata_o=data_q. Both are registered and stable while stalled.
- Retire counter:
  - Increments when valid_q & ~stall_i & ~flush_i & ~misalign_q, regardless of rf_we. Stores and x0 writes count.
  - Wraps modulo 2^CNT_W.
- valid_o = valid_q.
- Simultaneous flush and stall: flush wins; the held instruction is neither written nor counted.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with valid_i=1 → all outputs 0. Release → first capture appears one cycle later.
- ALU path: valid_i=1, wb_sel=0, rd=5, alu=0x1234_5678 → next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234_5678, retire_cnt_o increments 0→1.
- Load extension (DATA_W=32, mem_data=0x80FF_7F01):
  - byte, offset 3, signed → 0xFFFF_FF80.
  - byte, offset 3, unsigned → 0x0000_0080.
  - half, offset 2, signed → 0xFFFF_80FF.
  - half, offset 0, unsigned → 0x0000_7F01.
- Misaligned and x0:
  - half load at offset 1 → misalign_o=1, rf_we_o=0, counter unchanged.
  - ALU write to rd=0 → rf_we_o=0, counter increments.
- Stall/flush:
  - stall_i=1 for 3 cycles after capture → rf_we_o=0 and outputs stable; one write and one count on release.
  - flush_i and stall_i asserted together → valid_o=0 next cycle, no write, no count.
- DATA_W=64:
  - mem_data=0xFFFF_FFFF_8000_0000, word, offset 0, signed → 0xFFFF_FFFF_8000_0000.
  - Same, unsigned → 0x0000_0000_8000_0000.
  - Double with offset 4 → misalign_o=1.
  - Counter wrap check at CNT_W=4: 16 retirements → retire_cnt_o returns to 0.

Source files
------------

// File: rtl/wb_stage.sv
// Registered write-back stage: picks one of four result sources, extracts and extends load data,
// and drives the register-file write port one cycle after capture. Also counts retired instructions.
module wb_stage #(
    parameter  int DATA_W = 32,
    parameter  int REG_AW = 5,
    parameter  int CNT_W  = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              reg_write_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [1:0]        wb_sel_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] csr_data_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [OFF_W-1:0]  mem_offset_i,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              valid_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    logic              valid_q;
    logic              reg_write_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] data_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  retire_cnt_q;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep_mask;
    logic              sign_bit;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wdata_next;
    logic [2:0]        off3;
    logic              misalign_next;

    // The keep mask selects the loaded bits; everything above them is filled with the sign
    // (or zero). On a 32-bit datapath a double load degenerates to a full word.
    always_comb begin
        shifted   = mem_data_i >> {mem_offset_i, 3'b000};
        keep_mask = '1;
        sign_bit  = shifted[DATA_W-1];
        case (mem_size_i)
            2'd0: begin
                keep_mask = DATA_W'(8'hFF);
                sign_bit  = shifted[7];
            end
            2'd1: begin
                keep_mask = DATA_W'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            2'd2: begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = shifted[DATA_W-1];
            end
        endcase
        load_data = (shifted & keep_mask) |
                    (~keep_mask & {DATA_W{sign_bit & ~mem_unsigned_i}});
    end

    always_comb begin
        wdata_next    = alu_data_i;
        off3          = 3'(mem_offset_i);
        misalign_next = 1'b0;
        case (wb_sel_i)
            2'd1:    wdata_next = load_data;
            2'd2:    wdata_next = pc_plus4_i;
            2'd3:    wdata_next = csr_data_i;
            default: wdata_next = alu_data_i;
        endcase
        if (wb_sel_i == 2'd1) begin
            case (mem_size_i)
                2'd1:    misalign_next = off3[0];
                2'd2:    misalign_next = |off3[1:0];
                2'd3:    misalign_next = |off3;
                default: misalign_next = 1'b0;
            endcase
        end
    end

    // Flush only needs to kill the valid bit; the remaining fields are ignored until the next capture.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            misalign_q  <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            valid_q     <= valid_i;
            reg_write_q <= reg_write_i;
            rd_q        <= rd_addr_i;
            data_q      <= wdata_next;
            misalign_q  <= misalign_next;
        end
    end

    // Stores and x0 writes still retire; misaligned loads and killed instructions do not.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            retire_cnt_q <= '0;
        end else if (valid_q && !stall_i && !flush_i && !misalign_q) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign ready_o      = ~stall_i;
    assign rf_we_o      = valid_q & reg_write_q & (rd_q != '0) & ~misalign_q & ~stall_i;
    assign rf_waddr_o   = rd_q;
    assign rf_wdata_o   = data_q;
    assign valid_o      = valid_q;
    assign misalign_o   = misalign_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule
